if_pc_stage: RTL and testbench

- Instruction-fetch stage that owns the program-counter register and the IF/ID pipeline register.
- Drives the current PC to the PC incrementer and to instruction memory. Loads the incrementer's word-addressed result (PC+1) back as the next PC.
- Handles pipeline stall, flush and branch/jump redirect.
- Captures the fetched instruction plus its PC for the decode stage.

---
 rtl/if_pc_stage_pkg.sv | 30 +++
 rtl/if_pc_stage_ifid_reg.sv | 68 ++++++
 rtl/if_pc_stage.sv | 140 ++++++++++++++
 tb/tb_if_pc_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pc_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_pc_stage_pkg
//   Shared definitions for the instruction-fetch stage:
//     - fetch_state_e : fetch FSM encoding (BOOT = 0, RUN = 1)
//     - ifid_ctrl_t   : per-cycle control bundle sent to the IF/ID register
//     - NOP_INSTR     : bubble instruction written into IF/ID on flush/redirect
//     - DEFAULT_*     : default address / instruction widths
// -----------------------------------------------------------------------------
package if_pc_stage_pkg;

  localparam int DEFAULT_PC_WIDTH    = 32;
  localparam int DEFAULT_INSTR_WIDTH = 32;

  // addi x0, x0, 0 -- architecturally a no-op, so a squashed slot is harmless
  // even if something downstream ignores the valid bit.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // load   : capture the fetched instruction and its PC
  // bubble : replace IF/ID contents with a NOP (wins over load)
  typedef struct packed {
    logic load;
    logic bubble;
  } ifid_ctrl_t;

endpackage : if_pc_stage_pkg

// File: rtl/if_pc_stage_ifid_reg.sv
// -----------------------------------------------------------------------------
// if_pc_stage_ifid_reg
//   IF/ID pipeline register with hold / load / bubble control.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   synchronous active-low reset
//     ctrl       in   {load, bubble}; neither set = hold
//     pc_in      in   PC of the instruction being fetched
//     instr_in   in   fetched instruction word
//     ifid_pc    out  PC of the held instruction
//     ifid_instr out  held instruction (NOP when bubbled)
//     ifid_valid out  held instruction is real
// -----------------------------------------------------------------------------
module if_pc_stage_ifid_reg
  import if_pc_stage_pkg::*;
#(
  parameter int                     pc_width    = DEFAULT_PC_WIDTH,
  parameter int                     instr_width = DEFAULT_INSTR_WIDTH,
  parameter logic [instr_width-1:0] nop_instr   = instr_width'(NOP_INSTR)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  ifid_ctrl_t             ctrl,
  input  logic [pc_width-1:0]    pc_in,
  input  logic [instr_width-1:0] instr_in,
  output logic [pc_width-1:0]    ifid_pc,
  output logic [instr_width-1:0] ifid_instr,
  output logic                   ifid_valid
);

  logic [pc_width-1:0]    pc_q,    pc_d;
  logic [instr_width-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (ctrl.bubble) begin
      // The PC field is deliberately left alone on a bubble; only the
      // instruction and valid bit are squashed.
      instr_d = nop_instr;
      valid_d = 1'b0;
    end else if (ctrl.load) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= nop_instr;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign ifid_pc    = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_valid = valid_q;

endmodule : if_pc_stage_ifid_reg

// File: rtl/if_pc_stage.sv
// -----------------------------------------------------------------------------
// if_pc_stage
//   Instruction-fetch stage: owns the PC register, a BOOT/RUN fetch FSM, the
//   IF/ID pipeline register (sub-module) and a saturating fetch counter.
//   The PC incrementer and instruction memory are external and combinational
//   from read_addr.
//
//   Ports:
//     clk              in   rising-edge clock
//     rst_n            in   synchronous active-low reset
//     stall            in   hold PC and IF/ID
//     flush            in   squash IF/ID contents
//     redirect_valid   in   branch/jump taken this cycle
//     redirect_addr    in   branch/jump target
//     next_instr_addr  in   PC+1 from the external incrementer
//     instr_in         in   instruction memory data for read_addr
//     read_addr        out  current PC (registered)
//     ifid_pc          out  PC of the instruction in IF/ID
//     ifid_instr       out  instruction in IF/ID
//     ifid_valid       out  IF/ID holds a real instruction
//     fetch_count      out  saturating count of valid IF/ID loads
// -----------------------------------------------------------------------------
module if_pc_stage
  import if_pc_stage_pkg::*;
#(
  parameter int                     pc_width    = DEFAULT_PC_WIDTH,
  parameter int                     instr_width = DEFAULT_INSTR_WIDTH,
  parameter logic [pc_width-1:0]    reset_pc    = '0,
  parameter logic [instr_width-1:0] nop_instr   = instr_width'(NOP_INSTR),
  parameter int                     cnt_width   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   redirect_valid,
  input  logic [pc_width-1:0]    redirect_addr,
  input  logic [pc_width-1:0]    next_instr_addr,
  input  logic [instr_width-1:0] instr_in,
  output logic [pc_width-1:0]    read_addr,
  output logic [pc_width-1:0]    ifid_pc,
  output logic [instr_width-1:0] ifid_instr,
  output logic                   ifid_valid,
  output logic [cnt_width-1:0]   fetch_count
);

  fetch_state_e           state_q, state_d;
  logic [pc_width-1:0]    pc_q,    pc_d;
  logic [cnt_width-1:0]   cnt_q,   cnt_d;
  ifid_ctrl_t             ifid_ctrl;

  // ---------------------------------------------------------------------------
  // Next-state / PC / IF/ID control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    ifid_ctrl.load   = 1'b0;
    ifid_ctrl.bubble = 1'b0;

    case (state_q)
      BOOT: begin
        // Instruction memory gets one cycle to present data for reset_pc.
        // IF/ID is already a bubble from reset, so stall/flush are moot here;
        // a redirect is still honoured.
        state_d = RUN;
        if (redirect_valid) begin
          pc_d = redirect_addr;
        end
      end

      RUN: begin
        if (redirect_valid) begin
          // Redirect beats stall: the instruction being fetched is on the
          // wrong path, so it must not enter IF/ID.
          pc_d             = redirect_addr;
          ifid_ctrl.bubble = 1'b1;
        end else if (stall) begin
          ifid_ctrl.bubble = flush;
        end else begin
          // All-ones PC wraps to zero through the incrementer; accepted as-is.
          pc_d = next_instr_addr;
          if (flush) begin
            ifid_ctrl.bubble = 1'b1;
          end else begin
            ifid_ctrl.load = 1'b1;
          end
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Saturating fetch counter: counts only edges that load a valid instruction
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (ifid_ctrl.load && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= reset_pc;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID register
  // ---------------------------------------------------------------------------
  if_pc_stage_ifid_reg #(
    .pc_width    (pc_width),
    .instr_width (instr_width),
    .nop_instr   (nop_instr)
  ) u_ifid_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl       (ifid_ctrl),
    .pc_in      (pc_q),
    .instr_in   (instr_in),
    .ifid_pc    (ifid_pc),
    .ifid_instr (ifid_instr),
    .ifid_valid (ifid_valid)
  );

  assign read_addr   = pc_q;
  assign fetch_count = cnt_q;

endmodule : if_pc_stage

// File: tb/tb_if_pc_stage.sv
// -----------------------------------------------------------------------------
// tb_if_pc_stage
//   Two instances share one control stimulus:
//     A : reset_pc = 0,          cnt_width = 4  (exercises counter saturation)
//     B : reset_pc = 0xFFFFFFFF, cnt_width = 16 (exercises PC wrap-around)
//   Each instance has its own incrementer and instruction ROM driven from its
//   read_addr. A behavioural model tracks both and is compared every cycle;
//   a directed sequence adds hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_if_pc_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RST_PC  [2] = '{32'h0000_0000, 32'hFFFF_FFFF};
  localparam int          CNT_MAX [2] = '{15, 65535};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, flush, redirect_valid;
  logic [31:0] redirect_addr;

  logic [31:0] a_ra, a_next, a_instr, a_ipc, a_iinstr;
  logic        a_iv;
  logic [3:0]  a_cnt;
  logic [31:0] b_ra, b_next, b_instr, b_ipc, b_iinstr;
  logic        b_iv;
  logic [15:0] b_cnt;

  // Instruction ROM contents: distinct, address-dependent words.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0] ^ 16'hC35A, addr[31:16] + addr[15:0]};
  endfunction

  assign a_next  = a_ra + 32'd1;
  assign a_instr = mem_word(a_ra);
  assign b_next  = b_ra + 32'd1;
  assign b_instr = mem_word(b_ra);

  if_pc_stage #(
    .pc_width(32), .instr_width(32), .reset_pc(32'h0000_0000),
    .nop_instr(32'h0000_0013), .cnt_width(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .next_instr_addr(a_next), .instr_in(a_instr),
    .read_addr(a_ra), .ifid_pc(a_ipc), .ifid_instr(a_iinstr),
    .ifid_valid(a_iv), .fetch_count(a_cnt)
  );

  if_pc_stage #(
    .pc_width(32), .instr_width(32), .reset_pc(32'hFFFF_FFFF),
    .nop_instr(32'h0000_0013), .cnt_width(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .next_instr_addr(b_next), .instr_in(b_instr),
    .read_addr(b_ra), .ifid_pc(b_ipc), .ifid_instr(b_iinstr),
    .ifid_valid(b_iv), .fetch_count(b_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: what each stage must hold after every edge
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc [2];
  logic [31:0] m_ipc [2];
  logic [31:0] m_instr [2];
  logic        m_v [2];
  int          m_cnt [2];
  bit          m_boot [2];

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst_n !== 1'b1) begin
        m_pc[i] = RST_PC[i]; m_ipc[i] = 32'h0; m_instr[i] = NOP;
        m_v[i] = 1'b0; m_cnt[i] = 0; m_boot[i] = 1'b1;
      end else if (m_boot[i]) begin
        m_boot[i] = 1'b0;
        if (redirect_valid) m_pc[i] = redirect_addr;
      end else if (redirect_valid) begin
        m_pc[i] = redirect_addr; m_v[i] = 1'b0; m_instr[i] = NOP;
      end else if (stall) begin
        if (flush) begin m_v[i] = 1'b0; m_instr[i] = NOP; end
      end else begin
        if (flush) begin
          m_v[i] = 1'b0; m_instr[i] = NOP;
        end else begin
          m_ipc[i] = m_pc[i]; m_instr[i] = mem_word(m_pc[i]); m_v[i] = 1'b1;
          if (m_cnt[i] < CNT_MAX[i]) m_cnt[i] = m_cnt[i] + 1;
        end
        m_pc[i] = m_pc[i] + 32'd1;
      end
    end
  endtask

  // Compare process: update model at the edge, check DUTs 1 ns later.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("A.read_addr",   a_ra,           m_pc[0]);
    chk("A.ifid_pc",     a_ipc,          m_ipc[0]);
    chk("A.ifid_instr",  a_iinstr,       m_instr[0]);
    chk("A.ifid_valid",  {31'h0, a_iv},  {31'h0, m_v[0]});
    chk("A.fetch_count", {28'h0, a_cnt}, m_cnt[0]);
    chk("B.read_addr",   b_ra,           m_pc[1]);
    chk("B.ifid_pc",     b_ipc,          m_ipc[1]);
    chk("B.ifid_instr",  b_iinstr,       m_instr[1]);
    chk("B.ifid_valid",  {31'h0, b_iv},  {31'h0, m_v[1]});
    chk("B.fetch_count", {16'h0, b_cnt}, m_cnt[1]);
  end

  task automatic edge_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence with literal expectations, then randomized traffic
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_addr = 32'h0;

    edge_n(2);
    chk("lit.reset.A.read_addr",  a_ra, 32'h0);
    chk("lit.reset.B.read_addr",  b_ra, 32'hFFFF_FFFF);
    chk("lit.reset.A.ifid_instr", a_iinstr, 32'h0000_0013);
    chk("lit.reset.A.ifid_valid", {31'h0, a_iv}, 32'h0);
    chk("lit.reset.A.fetch_count", {28'h0, a_cnt}, 32'h0);
    rst_n = 1'b1;

    edge_n(1);                                        // BOOT edge
    chk("lit.boot.A.read_addr", a_ra, 32'h0);
    chk("lit.boot.A.ifid_valid", {31'h0, a_iv}, 32'h0);
    chk("lit.boot.B.read_addr", b_ra, 32'hFFFF_FFFF);
    edge_n(1);
    chk("lit.e2.A.read_addr", a_ra, 32'h1);
    chk("lit.e2.A.ifid_pc", a_ipc, 32'h0);
    chk("lit.e2.A.ifid_valid", {31'h0, a_iv}, 32'h1);
    chk("lit.wrap.B.read_addr", b_ra, 32'h0);
    chk("lit.wrap.B.ifid_pc", b_ipc, 32'hFFFF_FFFF);
    chk("lit.wrap.B.ifid_valid", {31'h0, b_iv}, 32'h1);
    edge_n(1);
    chk("lit.e3.A.read_addr", a_ra, 32'h2);
    chk("lit.e3.A.ifid_pc", a_ipc, 32'h1);
    edge_n(1);
    chk("lit.e4.A.read_addr", a_ra, 32'h3);
    chk("lit.e4.A.ifid_pc", a_ipc, 32'h2);
    chk("lit.e4.A.fetch_count", {28'h0, a_cnt}, 32'd3);

    edge_n(2);                                        // read_addr = 5
    stall = 1'b1;
    edge_n(2);
    chk("lit.stall.A.read_addr", a_ra, 32'h5);
    chk("lit.stall.A.ifid_pc", a_ipc, 32'h4);
    chk("lit.stall.A.ifid_instr", a_iinstr, mem_word(32'h4));
    stall = 1'b0;
    edge_n(1);
    chk("lit.resume.A.read_addr", a_ra, 32'h6);
    edge_n(1);                                        // read_addr = 7
    redirect_valid = 1'b1; redirect_addr = 32'h40; stall = 1'b1;
    edge_n(1);
    chk("lit.redir.A.read_addr", a_ra, 32'h40);
    chk("lit.redir.A.ifid_valid", {31'h0, a_iv}, 32'h0);
    chk("lit.redir.A.ifid_instr", a_iinstr, 32'h0000_0013);
    redirect_valid = 1'b0; stall = 1'b0;
    edge_n(1);
    chk("lit.redir2.A.ifid_pc", a_ipc, 32'h40);
    chk("lit.redir2.A.ifid_valid", {31'h0, a_iv}, 32'h1);

    redirect_valid = 1'b1; redirect_addr = 32'h9;
    edge_n(1);
    redirect_valid = 1'b0; flush = 1'b1;              // read_addr = 9
    edge_n(1);
    chk("lit.flush.A.read_addr", a_ra, 32'hA);
    chk("lit.flush.A.ifid_valid", {31'h0, a_iv}, 32'h0);
    chk("lit.flush.A.fetch_count", {28'h0, a_cnt}, 32'd8);
    flush = 1'b0;

    // Reset mid-stream with a valid instruction in IF/ID.
    redirect_valid = 1'b1; redirect_addr = 32'h1F;
    edge_n(1);
    redirect_valid = 1'b0;
    edge_n(1);
    chk("lit.pre_rst.A.read_addr", a_ra, 32'h20);
    chk("lit.pre_rst.A.ifid_valid", {31'h0, a_iv}, 32'h1);
    rst_n = 1'b0;
    edge_n(1);
    chk("lit.mid_rst.A.read_addr", a_ra, 32'h0);
    chk("lit.mid_rst.A.ifid_pc", a_ipc, 32'h0);
    chk("lit.mid_rst.A.ifid_valid", {31'h0, a_iv}, 32'h0);
    chk("lit.mid_rst.A.fetch_count", {28'h0, a_cnt}, 32'h0);
    rst_n = 1'b1;
    edge_n(1);
    chk("lit.reboot.A.read_addr", a_ra, 32'h0);
    edge_n(1);
    chk("lit.reboot2.A.read_addr", a_ra, 32'h1);

    // Redirect during BOOT, with stall/flush ignored.
    rst_n = 1'b0;
    edge_n(1);
    rst_n = 1'b1; stall = 1'b1; flush = 1'b1;
    redirect_valid = 1'b1; redirect_addr = 32'h80;
    edge_n(1);
    chk("lit.boot_redir.A.read_addr", a_ra, 32'h80);
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    edge_n(1);
    chk("lit.boot_redir2.A.ifid_pc", a_ipc, 32'h80);
    chk("lit.boot_redir2.A.fetch_count", {28'h0, a_cnt}, 32'd1);

    // Counter saturation (A is 4 bits wide, B is 16).
    rst_n = 1'b0;
    edge_n(1);
    rst_n = 1'b1;
    edge_n(1 + 15);
    chk("lit.sat15.A.fetch_count", {28'h0, a_cnt}, 32'd15);
    edge_n(2);
    chk("lit.sat17.A.fetch_count", {28'h0, a_cnt}, 32'd15);
    chk("lit.sat17.B.fetch_count", {16'h0, b_cnt}, 32'd17);
    chk("lit.sat17.A.read_addr", a_ra, 32'd17);

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n          = ($urandom_range(0, 199) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      flush          = ($urandom_range(0, 5) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      edge_n(1);
    end

    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    edge_n(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_if_pc_stage
